muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer for the multiply (opcode 6'b011000) and divide (opcode 6'b011010) operations the decoder classifies as R-type ALU ops. It runs an iterative shift-add multiplier and a restoring divider over WIDTH cycles. It writes the results to HI/LO registers and raises a stall so the PC and register-file write hold until the result is ready. It sits beside the ALU in the execute stage and is started by the control unit.

## Interface
- WIDTH, 32, operand width; HI/LO are WIDTH bits each, iteration count = WIDTH
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  1  0 = multiply, 1 = divide
- a  input  WIDTH  multiplicand / dividend (unsigned), captured with start
- b  input  WIDTH  multiplier / divisor (unsigned), captured with start
- abort  input  1  synchronous cancel of an operation in progress
- stall  output  1  hold PC/writeback; combinational = (start & IDLE) | busy
- busy  output  1  registered, high in RUN and DONE
- done  output  1  registered one-cycle pulse, HI/LO valid
- hi  output  WIDTH  product upper half / remainder
- lo  output  WIDTH  product lower half / quotient
- div_zero  output  1  set on completion of divide with b == 0, cleared on next accepted start

## Operation
- States: IDLE, RUN, DONE; encoding free, reset state IDLE.
- IDLE: if start, capture a, b, op, clear iteration counter and div_zero, go RUN; otherwise stay.
- Divide with b == 0: go straight to DONE (no RUN). lo = {WIDTH{1'b1}}, hi = a, div_zero = 1.
- RUN, multiply: 2*WIDTH-bit accumulator {P_hi, P_lo = multiplier}.
  - Each cycle, if the LSB is 1, add the multiplicand to the upper half with a WIDTH+1-bit carry.
  - Then shift the whole accumulator right 1, carry entering the MSB.
- RUN, divide (restoring): remainder R (WIDTH+1 bits), quotient Q = dividend.
  - Each cycle, shift {R,Q} left 1 and trial-subtract the divisor from R.
  - If the result is non-negative, keep it and set Q[0] = 1; else restore R and set Q[0] = 0.
- Counter increments each RUN cycle. When the WIDTH-th iteration completes (counter == WIDTH-1), load hi/lo from the accumulator and go DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. start is ignored in DONE.
- start while busy: ignored, no capture, no effect on the current operation.
- abort in RUN: next state IDLE, no done pulse, hi/lo/div_zero keep their previous values. abort in IDLE or DONE has no effect.
- abort and start in IDLE in the same cycle: start wins.
- hi/lo hold their value until the next completed operation.
- Arithmetic is unsigned only; results are exact (no truncation of the 2*WIDTH product).

## Timing
- Reset (rst_n low, any time, including mid-operation): state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, div_zero 0, accumulator cleared. Outputs take effect immediately, without waiting for a clock.
- start sampled high in IDLE at edge k:
  - stall is high combinationally in the cycle before edge k.
  - busy is high from edge k to edge k+WIDTH+1.
  - done is high for the cycle after edge k+WIDTH.
  - total latency from accept to done is WIDTH+1 cycles (33 for WIDTH=32).
- Divide by zero: done is high for the cycle after edge k+1.
- hi/lo/div_zero are updated at the same edge that raises done, and are stable while done = 1.
- Back-to-back: the earliest next accept is the first IDLE cycle after done, giving a minimum issue interval of WIDTH+2 cycles.

## Test plan
- Reset mid-RUN: assert rst_n low at iteration 10 -> all outputs 0 immediately; after release, state is IDLE and a new start works.
- Multiply 32'hFFFFFFFF x 32'hFFFFFFFF -> done exactly 33 cycles after accept, hi = 32'hFFFFFFFE, lo = 32'h00000001, busy high for 33 cycles.
- Divide 100 / 7 -> lo = 14, hi = 2, div_zero = 0, done after 33 cycles; then 5 / 9 -> lo = 0, hi = 5.
- Divide 1234 / 0 -> done after 2 cycles, lo = 32'hFFFFFFFF, hi = 1234, div_zero = 1; next start clears div_zero.
- Multiply 3 x 5 with start held high and new operands applied throughout RUN -> result 15 unaffected; hold start through DONE -> the new operation is accepted only in the following IDLE cycle.
- Abort at iteration 20 of 6 x 7, after a prior result hi = 0, lo = 9 -> no done pulse, hi/lo stay 0/9, busy drops the next cycle.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide sequencer with HI/LO results.
// Runs one shift-add or restoring-divide step per cycle and stalls the pipeline while busy.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_r;
    logic               zero_pend;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [2*WIDTH-1:0] step;

    // One shift-add step: conditional add into the upper half, then shift right with carry in.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] ph,
                                                    input logic [WIDTH-1:0] pl,
                                                    input logic [WIDTH-1:0] m);
        logic [WIDTH:0] sum;
        sum = {1'b0, ph} + (pl[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {sum, pl[WIDTH-1:1]};
    endfunction

    // One restoring step; the remainder stays below the divisor, so WIDTH bits hold it.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0] rs;
        logic [WIDTH:0] diff;
        rs   = {r, q[WIDTH-1]};
        diff = rs - {1'b0, d};
        if (!diff[WIDTH])
            return {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
        else
            return {rs[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    endfunction

    always_comb begin
        step = '0;
        if (op_r)
            step = div_step(acc_hi, acc_lo, opnd);
        else
            step = mul_step(acc_hi, acc_lo, opnd);
    end

    assign stall = (start && (state == S_IDLE)) || busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_r      <= 1'b0;
            zero_pend <= 1'b0;
            opnd      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r     <= op;
                        opnd     <= op ? b : a;
                        acc_lo   <= op ? a : b;
                        acc_hi   <= '0;
                        cnt      <= '0;
                        div_zero <= 1'b0;
                        busy     <= 1'b1;
                        if (op && (b == '0)) begin
                            zero_pend <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        acc_hi <= step[2*WIDTH-1:WIDTH];
                        acc_lo <= step[WIDTH-1:0];
                        cnt    <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            hi    <= step[2*WIDTH-1:WIDTH];
                            lo    <= step[WIDTH-1:0];
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Divide-by-zero spends an extra DONE cycle so its pulse lands one edge after accept.
                    if (zero_pend) begin
                        zero_pend <= 1'b0;
                        hi        <= acc_lo;
                        lo        <= '1;
                        div_zero  <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO/div_zero and latency queued at issue.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         abort = 1'b0;
    logic         stall, busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           c0;
        int           lat;
    } exp_t;

    exp_t sb[$];

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .abort(abort), .stall(stall), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [63:0] prod;
        e.c0 = 0;
        if (!o) begin
            prod  = {32'b0, x} * {32'b0, y};
            e.hi  = prod[63:32];
            e.lo  = prod[31:0];
            e.dz  = 1'b0;
            e.lat = W + 1;
        end else if (y == '0) begin
            e.hi  = x;
            e.lo  = '1;
            e.dz  = 1'b1;
            e.lat = 2;
        end else begin
            e.hi  = x % y;
            e.lo  = x / y;
            e.dz  = 1'b0;
            e.lat = W + 1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_zero", div_zero, e.dz);
                chk("latency", cyc - e.c0, e.lat);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit push, output int c0);
        exp_t e;
        tick();
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        c0    = cyc;
        #1;
        chk("stall_comb", stall, 1);
        if (push) begin
            e    = model(o, x, y);
            e.c0 = c0;
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout", 0, 1);
            sb.delete();
        end
    endtask

    initial begin
        int c0;
        int nb;
        exp_t e;

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_stall", stall, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Max multiply, with busy duration measured
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, c0);
        nb = 1;
        while (busy && nb < 100) begin
            tick();
            if (busy) nb++;
        end
        chk("busy_cycles", nb, W + 1);
        wait_done();

        issue(1, 100, 7, 1, c0);
        wait_done();
        issue(1, 5, 9, 1, c0);
        wait_done();

        issue(1, 1234, 0, 1, c0);
        wait_done();
        chk("dz_held", div_zero, 1);
        issue(1, 8, 2, 1, c0);
        chk("dz_cleared", div_zero, 0);
        chk("busy_after_accept", busy, 1);
        wait_done();

        for (int i = 0; i < 4; i++) begin
            issue(i[0], $urandom, (i == 3) ? 32'd3 : $urandom, 1, c0);
            wait_done();
        end

        // start held throughout; operands scrambled during RUN
        tick();
        start = 1'b1; op = 1'b0; a = 3; b = 5;
        e = model(0, 3, 5);
        e.c0 = cyc;
        sb.push_back(e);
        nb = 0;
        tick();
        while (!done && nb < 100) begin
            a = $urandom;
            b = $urandom;
            tick();
            nb++;
        end
        if (!done) chk("hold_timeout", 0, 1);
        a = 11; b = 13;
        e = model(0, 11, 13);
        e.c0 = cyc + 1;
        sb.push_back(e);
        tick();
        chk("hold_idle_busy", busy, 0);
        chk("hold_idle_stall", stall, 1);
        tick();
        chk("hold_accept_busy", busy, 1);
        start = 1'b0;
        wait_done();

        // Abort at iteration 20 after a prior 0/9 result
        issue(0, 3, 3, 1, c0);
        wait_done();
        issue(0, 6, 7, 0, c0);
        while (cyc < c0 + 20) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 9);
        repeat (40) tick();
        chk("abort_idle_stall", stall, 0);

        // Asynchronous reset at iteration 10
        issue(0, 32'h1234_5678, 32'h9ABC_DEF0, 0, c0);
        while (cyc < c0 + 10) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_dz", div_zero, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_busy", busy, 0);
        issue(0, 12, 12, 1, c0);
        wait_done();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
